// File: rtl/deser_pkg.sv
// ----------------------------------------------------------------------------
// deser_pkg
//   Shared definitions for the serial-to-parallel capture block.
//   - shift_state_t : shift FSM states (IDLE, SHIFT)
//   - WIDTH_MIN/MAX : legal word-length range for the WIDTH parameter
//   - cnt_width()   : bit-counter width able to hold the values 0..WIDTH
// ----------------------------------------------------------------------------
package deser_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shift_state_t;

  // The counter reaches WIDTH on the completing bit, so it needs room for
  // WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_shift_core.sv
// ----------------------------------------------------------------------------
// deser_shift_core
//   Shift register and bit counter for the serial capture path. The owning
//   FSM decides when a bit is the first of a word (load) or a follow-on
//   bit (shift); this block only stores bits and counts them.
//
// Parameters
//   WIDTH     : word length in bits (WIDTH_MIN..WIDTH_MAX)
//   MSB_FIRST : 1 = first received bit ends up in word[WIDTH-1]
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   load  in   store d as the first bit of a new word, count = 1
//   shift in   store d as the next bit of the current word, count + 1
//   d     in   serial data bit
//   word  out  shift register contents
//   count out  number of bits stored in the current word
// ----------------------------------------------------------------------------
module deser_shift_core
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             d,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] first_word;
  logic [WIDTH-1:0] next_word;

  // A first bit clears any leftover partial word, so a restart never mixes
  // bits from two frames.
  always_comb begin
    if (MSB_FIRST) begin
      first_word = {{(WIDTH-1){1'b0}}, d};
      next_word  = {word[WIDTH-2:0], d};
    end else begin
      first_word = {d, {(WIDTH-1){1'b0}}};
      next_word  = {d, word[WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (load) begin
      word  <= first_word;
      count <= CW'(1);
    end else if (shift) begin
      word  <= next_word;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/deser_capture.sv
// ----------------------------------------------------------------------------
// deser_capture
//   Serial-to-parallel word capture with a one-entry output register and a
//   valid/ready handshake. Capture of the next word continues while the
//   previous word waits for the consumer; a word that completes while the
//   output is still occupied and not being accepted is dropped and flagged.
//
// Parameters
//   WIDTH     : word length in bits (WIDTH_MIN..WIDTH_MAX)
//   MSB_FIRST : 1 = first received bit lands in q_data[WIDTH-1]
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   d       in   serial data bit, stable at clk rise
//   en      in   d is a valid bit this cycle
//   sof     in   with en: d is the first bit of a new word
//   q_data  out  assembled word
//   q_valid out  q_data holds an undelivered word
//   q_ready in   consumer accepts the word when q_valid && q_ready
//   ovf     out  sticky: a completed word was dropped (cleared only by rst)
//   busy    out  shift FSM is in SHIFT
// ----------------------------------------------------------------------------
module deser_capture
  import deser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             sof,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  shift_state_t     state;
  logic             armed;     // low for the first edge after reset release
  logic             done_q;    // a word completed on the previous edge
  logic             load;
  logic             shift;
  logic             last_bit;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    count;

  // --------------------------------------------------------------------------
  // Bit qualification. sof only matters together with en; in SHIFT a new
  // sof restarts the word, in IDLE a bit without sof is discarded.
  // --------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    if (armed && en) begin
      if (sof) begin
        load = 1'b1;
      end else if (state == SHIFT) begin
        shift = 1'b1;
      end
    end
  end

  // The restart path (load) reloads count to 1, so with WIDTH >= 2 only a
  // follow-on bit can ever be the completing one.
  assign last_bit = shift && (count == CW'(WIDTH - 1));

  deser_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .d     (d),
    .word  (word),
    .count (count)
  );

  // --------------------------------------------------------------------------
  // Shift FSM. busy is registered alongside the state so it is glitch-free.
  // --------------------------------------------------------------------------
  // NOTE: only control and output registers are reset here; the datapath
  // reset lives with the shift register in the core, and both clear
  // asynchronously so a partial word is gone the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      armed  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      armed  <= 1'b1;
      done_q <= last_bit;
      if (load) begin
        state <= SHIFT;
        busy  <= 1'b1;
      end else if (last_bit) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register and overflow flag. A completed word is presented one
  // edge after its last bit. The shift register may already be loading the
  // first bit of the next frame on that same edge; the output still picks
  // up the completed word because it samples the pre-edge contents.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
      ovf     <= 1'b0;
    end else if (done_q) begin
      if (!q_valid || q_ready) begin
        // Empty slot, or the old word leaves this edge: no bubble.
        q_data  <= word;
        q_valid <= 1'b1;
      end else begin
        // Slot occupied and not accepted: keep the old word, drop the new.
        ovf <= 1'b1;
      end
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_deser_capture.sv
// ----------------------------------------------------------------------------
// tb_deser_capture
//   Self-checking bench for deser_capture. Two instances share the stimulus:
//   dut_m (MSB_FIRST=1) and dut_l (MSB_FIRST=0), both WIDTH=8. Frames are
//   always sent with the first serial bit taken from word[7].
// ----------------------------------------------------------------------------
module tb_deser_capture;

  logic       clk;
  logic       rst;
  logic       d;
  logic       en;
  logic       sof;
  logic       q_ready;

  logic [7:0] q_data_m, q_data_l;
  logic       q_valid_m, q_valid_l;
  logic       ovf_m, ovf_l;
  logic       busy_m, busy_l;

  int n_tests = 0;
  int n_fail  = 0;

  deser_capture #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .en      (en),
    .sof     (sof),
    .q_data  (q_data_m),
    .q_valid (q_valid_m),
    .q_ready (q_ready),
    .ovf     (ovf_m),
    .busy    (busy_m)
  );

  deser_capture #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .en      (en),
    .sof     (sof),
    .q_data  (q_data_l),
    .q_valid (q_valid_l),
    .q_ready (q_ready),
    .ovf     (ovf_l),
    .busy    (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 ns after the rising edge.
  task automatic tick(input logic e, input logic s, input logic b);
    @(negedge clk);
    en  = e;
    sof = s;
    d   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Send word[7] first with sof. Between bits, insert gap cycles (fixed, or
  // i%4 when vary is set) that drive en=0 with sof=1 to show sof is ignored.
  // busy_bad counts cycles inside the frame where busy was not 1;
  // valid_seen counts cycles where q_valid was 1.
  task automatic send_frame(input logic [7:0] w, input int gap, input bit vary,
                            output int busy_bad, output int valid_seen);
    int g_n;
    busy_bad   = 0;
    valid_seen = 0;
    for (int i = 7; i >= 0; i--) begin
      tick(1'b1, (i == 7), w[i]);
      if (q_valid_m === 1'b1) valid_seen++;
      if (i > 0) begin
        if (busy_m !== 1'b1) busy_bad++;
        g_n = vary ? (i % 4) : gap;
        for (int g = 0; g < g_n; g++) begin
          tick(1'b0, 1'b1, 1'b1);
          if (busy_m !== 1'b1) busy_bad++;
          if (q_valid_m === 1'b1) valid_seen++;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    sof = 1'b0;
    d   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  typedef struct {
    logic [7:0] word;    // frame sent, first bit = word[7]
    int         gap;     // idle cycles between bits
    bit         vary;    // use gap = i%4 instead
    logic [7:0] exp_m;   // expected q_data, MSB_FIRST=1
    logic [7:0] exp_l;   // expected q_data, MSB_FIRST=0
  } vec_t;

  vec_t vecs [6];

  initial begin
    int bb, vs, bad;

    vecs[0] = '{word: 8'hB2, gap: 0, vary: 1'b0, exp_m: 8'hB2, exp_l: 8'h4D};
    vecs[1] = '{word: 8'h5A, gap: 0, vary: 1'b1, exp_m: 8'h5A, exp_l: 8'h5A};
    vecs[2] = '{word: 8'hF0, gap: 1, vary: 1'b0, exp_m: 8'hF0, exp_l: 8'h0F};
    vecs[3] = '{word: 8'h01, gap: 3, vary: 1'b0, exp_m: 8'h01, exp_l: 8'h80};
    vecs[4] = '{word: 8'hA5, gap: 2, vary: 1'b0, exp_m: 8'hA5, exp_l: 8'hA5};
    vecs[5] = '{word: 8'h6C, gap: 0, vary: 1'b0, exp_m: 8'h6C, exp_l: 8'h36};

    rst = 1'b1; en = 1'b0; sof = 1'b0; d = 1'b0; q_ready = 1'b1;

    // Reset state
    #12;
    check("rst_q_data_m",  q_data_m,  8'h00);
    check("rst_q_valid_m", q_valid_m, 1'b0);
    check("rst_ovf_m",     ovf_m,     1'b0);
    check("rst_busy_m",    busy_m,    1'b0);
    check("rst_q_data_l",  q_data_l,  8'h00);
    check("rst_q_valid_l", q_valid_l, 1'b0);
    check("rst_ovf_l",     ovf_l,     1'b0);
    check("rst_busy_l",    busy_l,    1'b0);

    // First rise after release: en+sof present but must be ignored
    @(negedge clk);
    rst = 1'b0; en = 1'b1; sof = 1'b1; d = 1'b1;
    @(posedge clk); #1;
    check("release_edge_ignored", busy_m, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("release_idle", busy_m, 1'b0);
    idle(1);

    // Table: one frame each, q_ready=1
    foreach (vecs[k]) begin
      send_frame(vecs[k].word, vecs[k].gap, vecs[k].vary, bb, vs);
      check($sformatf("v%0d_busy_in_frame", k), bb, 0);
      check($sformatf("v%0d_no_early_valid", k), vs, 0);
      check($sformatf("v%0d_busy_end", k), busy_m, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_valid_m", k), q_valid_m, 1'b1);
      check($sformatf("v%0d_data_m", k), q_data_m, vecs[k].exp_m);
      check($sformatf("v%0d_valid_l", k), q_valid_l, 1'b1);
      check($sformatf("v%0d_data_l", k), q_data_l, vecs[k].exp_l);
      tick(1'b0, 1'b0, 1'b0);
      check($sformatf("v%0d_valid_drop", k), q_valid_m, 1'b0);
      idle(1);
    end

    // No bubble: old word accepted on the edge the new one arrives
    q_ready = 1'b0;
    send_frame(8'hC3, 0, 1'b0, bb, vs);
    tick(1'b0, 1'b0, 1'b0);
    check("nb_first_valid", q_valid_m, 1'b1);
    check("nb_first_data",  q_data_m,  8'hC3);
    send_frame(8'h96, 0, 1'b0, bb, vs);
    check("nb_hold_data", q_data_m, 8'hC3);
    q_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("nb_valid_kept", q_valid_m, 1'b1);
    check("nb_new_data_m", q_data_m,  8'h96);
    check("nb_new_data_l", q_data_l,  8'h69);
    check("nb_no_ovf",     ovf_m,     1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("nb_valid_drop", q_valid_m, 1'b0);

    // Overflow: back-to-back 0xA5, 0x3C with q_ready=0
    q_ready = 1'b0;
    send_frame(8'hA5, 0, 1'b0, bb, vs);
    send_frame(8'h3C, 0, 1'b0, bb, vs);
    check("ovf_not_early", ovf_m, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    check("ovf_data_kept", q_data_m,  8'hA5);
    check("ovf_valid",     q_valid_m, 1'b1);
    check("ovf_set",       ovf_m,     1'b1);
    q_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("ovf_accept_valid", q_valid_m, 1'b0);
    idle(3);
    check("ovf_sticky", ovf_m, 1'b1);
    do_reset();
    check("ovf_cleared_by_rst", ovf_m, 1'b0);

    // Restart: sof after 5 bits, then full frame 0x81
    q_ready = 1'b1;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    send_frame(8'h81, 0, 1'b0, bb, vs);
    check("rs_no_early_valid", vs, 0);
    tick(1'b0, 1'b0, 1'b0);
    check("rs_valid", q_valid_m, 1'b1);
    check("rs_data",  q_data_m,  8'h81);
    check("rs_ovf",   ovf_m,     1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (q_valid_m !== 1'b0) bad++;
    end
    check("rs_single_word", bad, 0);

    // Async reset mid-frame while a word is pending
    q_ready = 1'b0;
    send_frame(8'hC3, 0, 1'b0, bb, vs);
    tick(1'b0, 1'b0, 1'b0);
    check("ar_pending_valid", q_valid_m, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check("ar_busy_before", busy_m, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_q_data_m",  q_data_m,  8'h00);
    check("ar_q_valid_m", q_valid_m, 1'b0);
    check("ar_ovf_m",     ovf_m,     1'b0);
    check("ar_busy_m",    busy_m,    1'b0);
    check("ar_q_data_l",  q_data_l,  8'h00);
    check("ar_busy_l",    busy_l,    1'b0);
    @(negedge clk);
    rst = 1'b0;
    q_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1, 1'b0, i[0]);
      if (q_valid_m !== 1'b0 || busy_m !== 1'b0) bad++;
    end
    tick(1'b0, 1'b1, 1'b1);
    if (busy_m !== 1'b0) bad++;
    for (int i = 0; i < 9; i++) begin
      tick(1'b1, 1'b0, 1'b1);
      if (q_valid_m !== 1'b0 || busy_m !== 1'b0) bad++;
    end
    check("ar_no_word_without_sof", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
